// File: rtl/m24_pkg.sv
// Shared constants, FSM states and slot drive table for the M24C08 reader.
package m24_pkg;

  localparam logic [6:0] DEVSEL = 7'b1010000;
  localparam int GAP_SLOTS = 3;

  localparam logic [5:0] S_START = 6'd0;
  localparam logic [5:0] S_ACK0  = 6'd9;
  localparam logic [5:0] S_ACK1  = 6'd18;
  localparam logic [5:0] S_SR    = 6'd19;
  localparam logic [5:0] S_ACK2  = 6'd28;
  localparam logic [5:0] S_DAT0  = 6'd29;
  localparam logic [5:0] S_NACK  = 6'd37;
  localparam logic [5:0] S_STOP  = 6'd38;
  localparam logic [5:0] S_GAP_END = S_STOP + 6'(GAP_SLOTS);

  typedef enum logic [1:0] {IDLE, XFER, GAP, DONE} state_t;

  // Returns {sdat, sda} to present during slot n.
  function automatic logic [1:0] slot_drive(
    input logic [5:0] n,
    input logic [6:0] addr
  );
    logic [7:0] w;
    logic [7:0] a;
    logic [7:0] r;
    logic [2:0] i;
    logic [1:0] d;
    w = {DEVSEL, 1'b0};
    a = {1'b0, addr};
    r = {DEVSEL, 1'b1};
    i = '0;
    d = 2'b11;
    unique case (1'b1)
      (n >= 6'd1 && n <= 6'd8): begin
        i = 3'(6'd8 - n);
        d = {1'b1, w[i]};
      end
      (n >= 6'd10 && n <= 6'd17): begin
        i = 3'(6'd17 - n);
        d = {1'b1, a[i]};
      end
      (n >= 6'd20 && n <= 6'd27): begin
        i = 3'(6'd27 - n);
        d = {1'b1, r[i]};
      end
      (n == S_ACK0 || n == S_ACK1 || n == S_ACK2): d = 2'b01;
      (n >= S_DAT0 && n < S_NACK): d = 2'b01;
      (n == S_STOP): d = 2'b10;
      default: d = 2'b11;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/m24_bit_timer.sv
// Tick-gated phase/slot counter for the M24C08 reader.
module m24_bit_timer
  import m24_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       run,
  input  logic       clr,
  input  logic       load,
  input  logic [5:0] load_slot,
  output logic [1:0] p,
  output logic [5:0] s,
  output logic       slot_end
);

  assign slot_end = tick && run && (p == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p <= '0;
      s <= '0;
    end else if (clr) begin
      p <= '0;
      s <= '0;
    end else if (tick && run) begin
      p <= p + 2'd1;
      if (p == 2'd3)
        s <= load ? load_slot : s + 6'd1;
    end
  end

endmodule

// File: rtl/m24_reader.sv
// I2C random-read master for the M24C08 EEPROM (one byte, block 0).
// Define M24_READER_ACK_CHECK_EN to check slave ACKs and abort on NACK.
module m24_reader
  import m24_pkg::*;
(
  input  logic       SYSCLK_IN,
  input  logic       RESET_N_IN,
  input  logic       INT400K_IN,
  input  logic       REQ_IN,
  input  logic [6:0] RD_ADDR_IN,
  output logic       BUSY_OUT,
  output logic [7:0] RD_DATA_OUT,
  output logic       RD_VALID_OUT,
  output logic       ERR_OUT,
  output logic       M24C08_SCL_OUT,
  output logic       M24C08_SDA_OUT,
  input  logic       M24C08_SDA_IN,
  output logic       M24C08_SDAT_OUT
);

  state_t state, state_nx;

  logic [1:0] p;
  logic [5:0] s;
  logic       slot_end;
  logic       accept;
  logic       run;
  logic       step;
  logic       load;
  logic       abort;
  logic       done_nx;
  logic [6:0] addr;
  logic [7:0] shreg;
  logic [7:0] rd_data;
  logic       scl;
  logic       sda;
  logic       sdat;

  assign accept  = REQ_IN && (state == IDLE);
  assign run     = (state == XFER) || (state == GAP);
  assign step    = INT400K_IN && (state == XFER);
  assign load    = abort && (state == XFER) && (s != S_STOP);
  assign done_nx = (state == GAP) && (state_nx == DONE);

  m24_bit_timer u_timer (
    .clk       (SYSCLK_IN),
    .rst_n     (RESET_N_IN),
    .tick      (INT400K_IN),
    .run       (run),
    .clr       (accept),
    .load      (load),
    .load_slot (S_STOP),
    .p         (p),
    .s         (s),
    .slot_end  (slot_end)
  );

  always_ff @(posedge SYSCLK_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) state <= IDLE;
    else             state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = XFER;
      XFER: if (slot_end && s == S_STOP) state_nx = GAP;
      GAP:  if (slot_end && s == S_GAP_END) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // STOP slot keeps SCL high so the bus ends idle.
  always_ff @(posedge SYSCLK_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      scl     <= 1'b1;
      sda     <= 1'b1;
      sdat    <= 1'b1;
      addr    <= '0;
      shreg   <= '0;
      rd_data <= '0;
    end else begin
      if (accept) addr <= RD_ADDR_IN;
      if (done_nx && !abort) rd_data <= shreg;
      if (step) begin
        scl <= (s == S_STOP) ? 1'b1 : ~p[1];
        unique case (p)
          2'd0: if (s == S_START) sda <= 1'b0;
          2'd1: begin
            if (s == S_SR) sda <= 1'b0;
            if (s == S_STOP) sda <= 1'b1;
            if (s >= S_DAT0 && s < S_NACK)
              shreg <= {shreg[6:0], M24C08_SDA_IN};
          end
          2'd2: begin
            if (abort && s != S_STOP)
              {sdat, sda} <= 2'b10;
            else if (s != S_STOP)
              {sdat, sda} <= slot_drive(s + 6'd1, addr);
          end
          default: ;
        endcase
      end
    end
  end

`ifdef M24_READER_ACK_CHECK_EN
  logic err;

  always_ff @(posedge SYSCLK_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      abort <= 1'b0;
      err   <= 1'b0;
    end else begin
      if (accept) begin
        abort <= 1'b0;
        err   <= 1'b0;
      end else if (step && p == 2'd1 && M24C08_SDA_IN &&
                   (s == S_ACK0 || s == S_ACK1 || s == S_ACK2)) begin
        abort <= 1'b1;
      end
      if (done_nx) err <= abort;
    end
  end

  assign ERR_OUT = err;
`else
  assign abort   = 1'b0;
  assign ERR_OUT = 1'b0;
`endif

  assign BUSY_OUT        = (state != IDLE);
  assign RD_VALID_OUT    = (state == DONE);
  assign RD_DATA_OUT     = rd_data;
  assign M24C08_SCL_OUT  = scl;
  assign M24C08_SDA_OUT  = sda;
  assign M24C08_SDAT_OUT = sdat;

endmodule

// File: tb/tb_m24_reader.sv
// Scoreboard bench for m24_reader with an I2C slave model on the bus.
module tb_m24_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic       req;
  logic [6:0] addr;
  logic       busy;
  logic [7:0] rd_data;
  logic       valid;
  logic       err;
  logic       scl;
  logic       sda_o;
  logic       sda_i;
  logic       sdat;
  logic       slave_low = 1'b0;

  typedef struct {
    logic [7:0] d;
    logic       e;
    int         lat;
  } exp_t;

  exp_t       exp_q[$];
  int         log_q[$];
  int         exp_log[$];
  logic [2:0] tr_a[$];
  logic [2:0] tr_b[$];

  int total = 0;
  int bad = 0;
  int tr_sel = 0;
  int tick_div = 1;
  int tcount = 0;
  int n_valid = 0;
  int n_push = 0;
  int clr_req = 0;
  int nack_idx = -1;
  logic [7:0] tx_data = 8'h00;

  m24_reader dut (
    .SYSCLK_IN       (clk),
    .RESET_N_IN      (rst_n),
    .INT400K_IN      (tick),
    .REQ_IN          (req),
    .RD_ADDR_IN      (addr),
    .BUSY_OUT        (busy),
    .RD_DATA_OUT     (rd_data),
    .RD_VALID_OUT    (valid),
    .ERR_OUT         (err),
    .M24C08_SCL_OUT  (scl),
    .M24C08_SDA_OUT  (sda_o),
    .M24C08_SDA_IN   (sda_i),
    .M24C08_SDAT_OUT (sdat)
  );

  assign sda_i = (sdat ? sda_o : 1'b1) & ~slave_low;

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  initial begin
    int c;
    c = 0;
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (c >= tick_div - 1) begin
        tick = 1'b1;
        c = 0;
      end else begin
        tick = 1'b0;
        c++;
      end
    end
  end

  // Monitor: tick counter, bus trace, scoreboard pop on VALID.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (!busy) tcount = 0;
      else if (tick && !valid) begin
        tcount++;
        if (tr_sel == 1) tr_a.push_back({scl, sda_o, sdat});
        if (tr_sel == 2) tr_b.push_back({scl, sda_o, sdat});
      end
      if (valid) begin
        n_valid++;
        if (exp_q.size() == 0) begin
          check("valid_unexpected", n_valid, n_push);
        end else begin
          e = exp_q.pop_front();
          check("rd_data", int'(rd_data), int'(e.d));
          check("err", int'(err), int'(e.e));
          check("latency", tcount, e.lat);
        end
      end
    end
  end

  // Slave: decodes START/STOP/bytes, ACKs writes, returns tx_data.
  initial begin
    int bitn;
    int bc;
    int nb;
    int seen;
    logic ps;
    logic pd;
    logic rd;
    logic [7:0] sh;
    bitn = 0; bc = 0; nb = 0; seen = 0;
    ps = 1'b1; pd = 1'b1; rd = 1'b0; sh = '0;
    forever begin
      @(negedge clk);
      if (seen != clr_req) begin
        seen = clr_req;
        log_q.delete();
        bitn = 0; bc = 0; nb = 0; rd = 1'b0;
        slave_low = 1'b0;
      end else if (scl && ps && pd && !sda_i) begin
        log_q.push_back('h200);
        bitn = 0; bc = 0; rd = 1'b0;
      end else if (scl && ps && !pd && sda_i) begin
        log_q.push_back('h300);
        bitn = 0;
        slave_low = 1'b0;
      end else if (scl && !ps) begin
        bitn++;
        if (bitn <= 8) begin
          sh = {sh[6:0], sda_i};
        end else begin
          log_q.push_back(int'({sda_i, sh}));
          if (bc == 0) rd = sh[0];
          bc++; nb++;
          bitn = 0;
        end
      end else if (!scl && ps) begin
        if (rd && bc == 1)
          slave_low = (bitn < 8) ? ~tx_data[7 - bitn] : 1'b0;
        else
          slave_low = (bitn == 8) && (nb != nack_idx);
      end
      ps = scl;
      pd = sda_i;
    end
  end

  task automatic do_req(input logic [6:0] a, input logic [7:0] d,
                        input logic e, input int lat, input bit push);
    if (push) begin
      exp_q.push_back('{d, e, lat});
      n_push++;
    end
    @(posedge clk);
    #2;
    req = 1'b1;
    addr = a;
    @(posedge clk);
    #2;
    req = 1'b0;
  endtask

  task automatic start_read(input logic [6:0] a, input logic [7:0] d,
                            input int nk, input logic [7:0] ed,
                            input logic ee, input int lat,
                            input bit abrt, input bit push);
    tx_data = d;
    nack_idx = nk;
    clr_req++;
    repeat (2) @(negedge clk);
    exp_log.delete();
    exp_log.push_back('h200);
    exp_log.push_back('h0A0 + ((nk == 0) ? 'h100 : 0));
    exp_log.push_back(int'(a) + ((nk == 1) ? 'h100 : 0));
    if (!abrt) begin
      exp_log.push_back('h200);
      exp_log.push_back('h0A1 + ((nk == 2) ? 'h100 : 0));
      exp_log.push_back('h100 + int'(d));
    end
    exp_log.push_back('h300);
    do_req(a, ed, ee, lat, push);
  endtask

  task automatic finish_read(input string nm);
    int n;
    int diffs;
    n = 0;
    diffs = 0;
    while (exp_q.size() != 0 && n < tick_div * 200 + 100) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_pending"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (4) @(negedge clk);
    check({nm, "_bus_len"}, log_q.size(), exp_log.size());
    for (int i = 0; i < log_q.size() && i < exp_log.size(); i++)
      if (log_q[i] != exp_log[i]) diffs++;
    check({nm, "_bus"}, diffs, 0);
  endtask

  task automatic wait_ticks(input int t);
    int g;
    g = 0;
    while (tcount < t && g < t * tick_div * 4 + 100) begin
      @(negedge clk);
      g++;
    end
    check("reach_tick", int'(tcount >= t), 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int diffs;
    rst_n = 1'b1;
    req = 1'b0;
    addr = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_scl", int'(scl), 1);
    check("rst_sda", int'(sda_o), 1);
    check("rst_sdat", int'(sdat), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_data", int'(rd_data), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_err", int'(err), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    tick_div = 1;
    tr_sel = 1;
    start_read(7'h15, 8'hA5, -1, 8'hA5, 1'b0, 168, 1'b0, 1'b1);
    finish_read("t1");

    tick_div = 250;
    tr_sel = 2;
    start_read(7'h15, 8'hA5, -1, 8'hA5, 1'b0, 168, 1'b0, 1'b1);
    finish_read("t2");
    tr_sel = 0;
    check("trace_len_fast", tr_a.size(), 168);
    check("trace_len_slow", tr_b.size(), 168);
    diffs = 0;
    for (int i = 0; i < tr_a.size() && i < tr_b.size(); i++)
      if (tr_a[i] != tr_b[i]) diffs++;
    check("trace_equal", diffs, 0);

    tick_div = 2;
    start_read(7'h15, 8'hA5, -1, 8'hA5, 1'b0, 168, 1'b0, 1'b1);
    wait_ticks(50);
    do_req(7'h7F, 8'h00, 1'b0, 0, 1'b0);
    finish_read("t3");

    tick_div = 1;
`ifdef M24_READER_ACK_CHECK_EN
    start_read(7'h15, 8'h3C, 1, 8'hA5, 1'b1, 92, 1'b1, 1'b1);
`else
    start_read(7'h15, 8'h3C, 1, 8'h3C, 1'b0, 168, 1'b0, 1'b1);
`endif
    finish_read("t5");

    start_read(7'h15, 8'hA5, -1, 8'hA5, 1'b0, 168, 1'b0, 1'b0);
    check("err_clear", int'(err), 0);
    wait_ticks(90);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_scl", int'(scl), 1);
    check("arst_sda", int'(sda_o), 1);
    check("arst_sdat", int'(sdat), 1);
    check("arst_busy", int'(busy), 0);
    check("arst_data", int'(rd_data), 0);
    exp_q.delete();
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    start_read(7'h00, 8'hFF, -1, 8'hFF, 1'b0, 168, 1'b0, 1'b1);
    finish_read("t4");

    start_read(7'h7F, 8'h00, -1, 8'h00, 1'b0, 168, 1'b0, 1'b1);
    finish_read("t6");

    check("valid_count", n_valid, n_push);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
